// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the feature-map pooling buffer.
package cnn_pkg;

   localparam int DW    = 32;            // signed sample width
   localparam int IN_W  = 24;            // conv output row/col length
   localparam int OUT_W = 12;            // pooled row/col length
   localparam int DEPTH = OUT_W * OUT_W; // pooled map entries (144)
   localparam int AW    = $clog2(DEPTH); // fmap address width
   localparam int RCW   = $clog2(IN_W);  // row/column counter width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2,
      ST_READ  = 2'd3
   } state_e;

   // Signed maximum by compare-select; ties keep the first operand.
   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/fmap_ram_144x32.sv
// Pooled feature-map storage: one synchronous write port and one read port.
// The array is deliberately left without reset; every entry is rewritten by
// each complete capture before it can be read.
module fmap_ram_144x32
   import cnn_pkg::*;
(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Synchronous write of one pooled sample.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // The read port is combinational; the top registers the value it selects.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fmap_pool_buf.sv
// Captures a 24x24 conv result map, 2x2 max-pools it on the fly into a 12x12
// map, and streams the pooled map out with a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. On the input side in_ready is 1 only while capturing; on the
// output side out_data/out_last are held unchanged while out_valid=1 and
// out_ready=0, and out_valid never drops without a transfer except on reset.
module fmap_pool_buf
   import cnn_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   output logic                 full,
   input  logic                 rd_start,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_data,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 done
);

   state_e                state_q, state_d;
   logic [RCW-1:0]        r_q, r_d;
   logic [RCW-1:0]        c_q, c_d;
   logic signed [DW-1:0]  pair_q, pair_d;
   logic signed [DW-1:0]  lb_q [OUT_W];
   logic signed [DW-1:0]  lb_d [OUT_W];
   logic [AW-1:0]         rd_idx_q, rd_idx_d;
   logic                  out_valid_q, out_valid_d;
   logic signed [DW-1:0]  out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  done_q, done_d;

   logic                  accept;
   logic                  load;
   logic                  hs_last;
   logic                  we;
   logic [AW-1:0]         waddr;
   logic [RCW-2:0]        half_c;
   logic signed [DW-1:0]  pair_max;
   logic signed [DW-1:0]  pool_max;
   logic [DW-1:0]         rdata;

   assign accept  = (state_q == ST_WRITE) && in_valid;
   // Output register may take a new sample when empty or being drained.
   assign load    = !out_valid_q || out_ready;
   assign hs_last = out_valid_q && out_ready && out_last_q;

   // Pooling datapath: horizontal pair max, then vertical max with the line buffer.
   assign half_c   = c_q[RCW-1:1];
   assign pair_max = smax(pair_q, in_data);
   assign pool_max = smax(lb_q[half_c], pair_max);
   assign we       = accept && r_q[0] && c_q[0];
   assign waddr    = AW'(r_q[RCW-1:1]) * AW'(OUT_W) + AW'(half_c);

   fmap_ram_144x32 u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (pool_max),
      .raddr (rd_idx_q),
      .rdata (rdata)
   );

   // Next-state, capture counters, pooling registers and readout register.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      c_d         = c_q;
      pair_d      = pair_q;
      lb_d        = lb_q;
      rd_idx_d    = rd_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            r_d = '0;
            c_d = '0;
            if (start) begin
               state_d = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (accept) begin
               if (!c_q[0]) begin
                  pair_d = in_data;
               end else if (!r_q[0]) begin
                  lb_d[half_c] = pair_max;
               end
               if (c_q == RCW'(IN_W - 1)) begin
                  c_d = '0;
                  if (r_q == RCW'(IN_W - 1)) begin
                     r_d     = '0;
                     state_d = ST_FULL;
                  end else begin
                     r_d = r_q + RCW'(1);
                  end
               end else begin
                  c_d = c_q + RCW'(1);
               end
            end
         end

         ST_FULL: begin
            rd_idx_d = '0;
            if (rd_start) begin
               state_d = ST_READ;
            end
         end

         ST_READ: begin
            if (hs_last) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               done_d      = 1'b1;
            end else if (load) begin
               // Index DEPTH-1 is loaded once; after that the register just holds.
               out_valid_d = 1'b1;
               out_data_d  = rdata;
               out_last_d  = (rd_idx_q == AW'(DEPTH - 1));
               if (rd_idx_q != AW'(DEPTH - 1)) begin
                  rd_idx_d = rd_idx_q + AW'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         r_q         <= '0;
         c_q         <= '0;
         pair_q      <= '0;
         rd_idx_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         pair_q      <= pair_d;
         rd_idx_q    <= rd_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   // Line buffer holds even-row pair maxima; it is always written before read.
   always_ff @(posedge clk) begin
      lb_q <= lb_d;
   end

   assign in_ready  = (state_q == ST_WRITE);
   assign full      = (state_q == ST_FULL);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fmap_pool_buf.sv
// Bench for fmap_pool_buf: directed maps, a 2x2 block-max model, and a
// negedge compare process on the output stream.
module tb_fmap_pool_buf;
   import cnn_pkg::*;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b1;
   logic                 start = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_data = '0;
   logic                 in_ready;
   logic                 full;
   logic                 rd_start = 1'b0;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic                 out_ready = 1'b0;
   logic                 out_last;
   logic                 done;

   fmap_pool_buf dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .full      (full),
      .rd_start  (rd_start),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_last  (out_last),
      .done      (done)
   );

   // clock
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0]        exp_q[$];
   logic signed [DW-1:0] img [IN_W][IN_W];

   // compare-process state
   int            hs_cnt = 0;
   int            hs_total = 0;
   int            done_cnt = 0;
   bit            last_pending = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // ---------------- model ----------------
   function automatic void fill_ramp();
      for (int r = 0; r < IN_W; r++)
         for (int c = 0; c < IN_W; c++)
            img[r][c] = r * IN_W + c;
   endfunction

   function automatic void fill_const(input int v);
      for (int r = 0; r < IN_W; r++)
         for (int c = 0; c < IN_W; c++)
            img[r][c] = v;
   endfunction

   function automatic void build_expected();
      int br;
      int bc;
      logic signed [DW-1:0] m;
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++) begin
         br = k / OUT_W;
         bc = k % OUT_W;
         m  = img[2*br][2*bc];
         for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
               if (img[2*br+dr][2*bc+dc] > m) m = img[2*br+dr][2*bc+dc];
         exp_q.push_back(m);
      end
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rstn) begin
         hs_cnt       = 0;
         last_pending = 0;
         prev_stall   = 0;
      end else begin
         if (last_pending || done) begin
            check("done_pulse", {31'd0, done}, {31'd0, last_pending});
            if (last_pending) begin
               check("valid_after_last", {31'd0, out_valid}, 0);
               done_cnt++;
            end
            last_pending = 0;
         end
         if (prev_stall && out_valid) begin
            check("stall_data", out_data, prev_data);
            check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_output: got %0d expected no output", out_data);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
               check("out_last", {31'd0, out_last}, (hs_cnt == DEPTH - 1) ? 1 : 0);
            end
            hs_cnt++;
            hs_total++;
            if (hs_cnt == DEPTH) begin
               last_pending = 1;
               hs_cnt       = 0;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Feed img row-major; gap randomises in_valid; optional rd_start poke and abort point.
   task automatic write_map(input bit gap, input int poke_rd_at, input int abort_at);
      int  n = 0;
      int  cyc = 0;
      bit  acc;
      while (n < IN_W * IN_W && cyc < 5000 && n != abort_at) begin
         in_data  = img[n / IN_W][n % IN_W];
         in_valid = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
         rd_start = (n == poke_rd_at);
         acc      = in_valid && in_ready;
         tick();
         if (rd_start) begin
            rd_start = 1'b0;
            check("rd_start_in_write_ready", {31'd0, in_ready}, 1);
            check("rd_start_in_write_full", {31'd0, full}, 0);
         end
         if (acc) n++;
         cyc++;
      end
      in_valid = 1'b0;
      rd_start = 1'b0;
      if (abort_at < 0) begin
         check("accepted_samples", n, IN_W * IN_W);
         check("full_after_map", {31'd0, full}, 1);
      end
   endtask

   // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1.
   task automatic read_map(input int mode);
      int d0 = done_cnt;
      int h0 = hs_total;
      int cyc = 0;
      out_ready = 1'b0;
      rd_start  = 1'b1;
      tick();
      rd_start = 1'b0;
      check("read_entry_valid", {31'd0, out_valid}, 0);
      check("read_entry_full", {31'd0, full}, 0);
      tick();
      check("first_valid", {31'd0, out_valid}, 1);
      check("first_data", out_data, exp_q[0]);
      while (done_cnt == d0 && cyc < 2000) begin
         if (mode == 0) out_ready = 1'b1;
         else           out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("done_count", done_cnt - d0, 1);
      check("handshakes", hs_total - h0, DEPTH);
      check("exp_empty", exp_q.size(), 0);
      check("idle_valid", {31'd0, out_valid}, 0);
      check("idle_full", {31'd0, full}, 0);
      check("idle_ready", {31'd0, in_ready}, 0);
   endtask

   task automatic full_cycle(input bit gap, input int mode);
      build_expected();
      pulse_start();
      check("write_ready", {31'd0, in_ready}, 1);
      write_map(gap, -1, -1);
      read_map(mode);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0;
      #1 rstn = 1'b0;
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 0);
      check("rst_full", {31'd0, full}, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", {31'd0, out_last}, 0);
      check("rst_done", {31'd0, done}, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      tick();

      // samples offered in IDLE are dropped
      in_valid = 1'b1;
      in_data  = 777;
      repeat (4) tick();
      check("idle_drop_ready", {31'd0, in_ready}, 0);
      check("idle_drop_full", {31'd0, full}, 0);
      in_valid = 1'b0;

      // ramp, with rd_start poked during WRITE and start/samples poked in FULL
      fill_ramp();
      build_expected();
      check("model_ramp_k0", exp_q[0], 25);
      check("model_ramp_k13", exp_q[13], 75);
      check("model_ramp_k143", exp_q[143], 575);
      pulse_start();
      write_map(1'b0, 100, -1);
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = -9;
      tick();
      start = 1'b0;
      repeat (3) tick();
      in_valid = 1'b0;
      check("start_in_full", {31'd0, full}, 1);
      check("full_drop_ready", {31'd0, in_ready}, 0);
      read_map(0);

      // backpressure
      fill_ramp();
      full_cycle(1'b0, 1);

      // signed compare
      fill_const(-5);
      img[1][1] = -2;
      build_expected();
      check("model_signed_k0", exp_q[0], -2);
      check("model_signed_k1", exp_q[1], -5);
      full_cycle(1'b0, 0);

      // gapped input
      fill_ramp();
      full_cycle(1'b1, 0);

      // reset at sample 300 of WRITE, then a fresh full map
      fill_const(9999);
      pulse_start();
      write_map(1'b0, -1, 300);
      rstn = 1'b0;
      #1;
      check("abort_w_ready", {31'd0, in_ready}, 0);
      check("abort_w_full", {31'd0, full}, 0);
      tick();
      rstn = 1'b1;
      repeat (3) tick();
      check("abort_w_waits", {31'd0, in_ready}, 0);
      fill_ramp();
      full_cycle(1'b0, 0);

      // reset during READ near index 50
      fill_ramp();
      build_expected();
      pulse_start();
      write_map(1'b0, -1, -1);
      d0 = done_cnt;
      rd_start = 1'b1;
      tick();
      rd_start  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 400 && hs_cnt < 50; i++) tick();
      check("abort_r_reached", hs_cnt, 50);
      rstn = 1'b0;
      #1;
      check("abort_r_valid", {31'd0, out_valid}, 0);
      check("abort_r_last", {31'd0, out_last}, 0);
      check("abort_r_full", {31'd0, full}, 0);
      out_ready = 1'b0;
      exp_q.delete();
      tick();
      rstn = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      check("abort_r_idle_valid", {31'd0, out_valid}, 0);
      check("abort_r_idle_ready", {31'd0, in_ready}, 0);
      check("abort_r_no_done", done_cnt - d0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
